// File: rtl/led_pkg.sv
// Shared mode encodings, ping-pong direction type and speed divider helpers
// for the LED pattern engine.
package led_pkg;

  localparam logic [1:0] MODE_ROL   = 2'd0;
  localparam logic [1:0] MODE_ROR   = 2'd1;
  localparam logic [1:0] MODE_PING  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Three bits so the slowest speed (8 ticks per step) is reachable.
  localparam int DIV_W = 3;

  function automatic logic [DIV_W-1:0] step_thresh(input logic [1:0] speed);
    logic [DIV_W-1:0] thr;
    case (speed)
      2'd0:    thr = 3'd0;
      2'd1:    thr = 3'd1;
      2'd2:    thr = 3'd3;
      default: thr = 3'd7;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler (exact TIME_CNT-cycle tick) plus tick divider producing a
// one-cycle step enable every 2^speed ticks; hold freezes both counters.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int TIME_CNT = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       hold,
  input  logic [1:0] speed,
  output logic       step_en
);

  localparam int PW = (TIME_CNT > 1) ? $clog2(TIME_CNT) : 1;

  logic [PW-1:0]    r_presc;
  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic             w_fire;

  assign w_tick  = (r_presc == PW'(TIME_CNT - 1));
  // >= rather than == so lowering speed mid-count fires on the next tick.
  assign w_fire  = w_tick && (r_div >= step_thresh(speed));
  assign step_en = w_fire && !hold && !clear;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_presc <= '0;
      r_div   <= '0;
    end else if (!hold) begin
      if (w_tick) begin
        r_presc <= '0;
        r_div   <= w_fire ? '0 : r_div + DIV_W'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: pattern register, ping-pong direction state, mode mux
// and registered step strobe, paced by led_tick_gen.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int               LED_W        = 8,
  parameter int               TIME_CNT     = 50_000_000,
  parameter logic [LED_W-1:0] INIT_PATTERN = {LED_W{1'b1}} >> (LED_W - LED_W / 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             pause,
  input  logic             load,
  input  logic [LED_W-1:0] pattern_in,
  output logic [LED_W-1:0] led,
  output logic             step,
  output logic             dbg_dir
);

  logic [LED_W-1:0] r_led;
  logic             r_step;
  dir_e             r_dir;
  logic             w_step_en;
  logic [LED_W-1:0] w_next_led;
  dir_e             w_next_dir;

  led_tick_gen #(
    .TIME_CNT (TIME_CNT)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clear   (load),
    .hold    (pause),
    .speed   (speed),
    .step_en (w_step_en)
  );

  always_comb begin
    w_next_led = r_led;
    w_next_dir = r_dir;
    case (mode)
      MODE_ROL: w_next_led = {r_led[LED_W-2:0], r_led[LED_W-1]};
      MODE_ROR: w_next_led = {r_led[0], r_led[LED_W-1:1]};
      MODE_PING: begin
        // Both ends lit or all dark: nowhere to bounce, so hold.
        if (!(r_led[LED_W-1] && r_led[0]) && (r_led != '0)) begin
          if (r_dir == DIR_LEFT) begin
            if (r_led[LED_W-1]) begin
              w_next_dir = DIR_RIGHT;
              w_next_led = r_led >> 1;
            end else begin
              w_next_led = r_led << 1;
            end
          end else begin
            if (r_led[0]) begin
              w_next_dir = DIR_LEFT;
              w_next_led = r_led << 1;
            end else begin
              w_next_led = r_led >> 1;
            end
          end
        end
      end
      default: w_next_led = ~r_led;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led  <= INIT_PATTERN;
      r_dir  <= DIR_LEFT;
      r_step <= 1'b0;
    end else if (load) begin
      r_led  <= pattern_in;
      r_dir  <= DIR_LEFT;
      r_step <= 1'b0;
    end else if (pause) begin
      r_step <= 1'b0;
    end else if (w_step_en) begin
      r_led  <= w_next_led;
      r_dir  <= w_next_dir;
      r_step <= 1'b1;
    end else begin
      r_step <= 1'b0;
    end
  end

  assign led     = r_led;
  assign step    = r_step;
  assign dbg_dir = r_dir;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at TIME_CNT=4, LED_W=8: rotate, ping-pong,
// blink with speed change, pause, load-over-step and mid-run reset.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       pause;
  logic       load;
  logic [7:0] pattern_in;
  logic [7:0] led;
  logic       step;
  logic       dbg_dir;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] rol_seq [9];
  logic [7:0] ping_seq[6];

  led_pattern_gen #(
    .LED_W    (8),
    .TIME_CNT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .speed      (speed),
    .pause      (pause),
    .load       (load),
    .pattern_in (pattern_in),
    .led        (led),
    .step       (step),
    .dbg_dir    (dbg_dir)
  );

  always #5 clk = ~clk;

  // Advance n clock edges and settle just after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rol_seq  = '{8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE1, 8'hC3, 8'h87, 8'h0F};
    ping_seq = '{8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0, 8'h78};

    rst = 1'b1; mode = 2'd0; speed = 2'd0; pause = 1'b0; load = 1'b0; pattern_in = 8'h00;
    cyc(2);
    rst = 1'b0;
    chk("reset_led", led, 8'h0F);
    chk("reset_step", {7'b0, step}, 8'h00);
    chk("reset_dir", {7'b0, dbg_dir}, 8'h00);

    // Rotate-left: first step at edge 4, then every 4 cycles.
    cyc(3);
    chk("rol_pre_e4", led, 8'h0F);
    chk("rol_pre_e4_step", {7'b0, step}, 8'h00);
    cyc(1);
    chk("rol_e4", led, 8'h1E);
    chk("rol_e4_step", {7'b0, step}, 8'h01);
    cyc(1);
    chk("rol_e5_step", {7'b0, step}, 8'h00);
    cyc(3);
    chk("rol_e8", led, 8'h3C);
    chk("rol_e8_step", {7'b0, step}, 8'h01);
    for (int i = 3; i <= 8; i++) begin
      cyc(4);
      chk($sformatf("rol_step%0d", i), led, rol_seq[i]);
    end

    // Ping-pong from 0000_1111: four left shifts then bounce right.
    mode = 2'd2;
    for (int i = 1; i <= 5; i++) begin
      cyc(4);
      chk($sformatf("ping_step%0d", i), led, ping_seq[i]);
    end
    chk("ping_dir_right", {7'b0, dbg_dir}, 8'h01);
    load = 1'b1; pattern_in = 8'h81;
    cyc(1);
    load = 1'b0;
    chk("ping_load_led", led, 8'h81);
    chk("ping_load_dir", {7'b0, dbg_dir}, 8'h00);
    cyc(4);
    chk("ping_both_ends_hold1", led, 8'h81);
    cyc(4);
    chk("ping_both_ends_hold2", led, 8'h81);

    // Blink at speed 2 (16 cycles), then drop to speed 0 mid-count.
    mode = 2'd3; speed = 2'd2; load = 1'b1; pattern_in = 8'h0F;
    cyc(1);
    load = 1'b0;
    cyc(15);
    chk("blink_pre16", led, 8'h0F);
    cyc(1);
    chk("blink_16", led, 8'hF0);
    chk("blink_16_step", {7'b0, step}, 8'h01);
    cyc(16);
    chk("blink_32", led, 8'h0F);
    cyc(6);
    speed = 2'd0;
    cyc(1);
    chk("blink_speed_pre_tick", led, 8'h0F);
    cyc(1);
    chk("blink_speed_next_tick", led, 8'hF0);
    chk("blink_speed_step", {7'b0, step}, 8'h01);
    cyc(4);
    chk("blink_speed0_follow", led, 8'h0F);

    // Pause 10 cycles mid-period: step slips by exactly 10.
    mode = 2'd0;
    cyc(2);
    pause = 1'b1;
    cyc(5);
    chk("pause_mid_led", led, 8'h0F);
    chk("pause_mid_step", {7'b0, step}, 8'h00);
    cyc(5);
    chk("pause_end_led", led, 8'h0F);
    chk("pause_end_step", {7'b0, step}, 8'h00);
    pause = 1'b0;
    cyc(1);
    chk("pause_after1", led, 8'h0F);
    cyc(1);
    chk("pause_delayed_step", led, 8'h1E);
    chk("pause_delayed_step_pulse", {7'b0, step}, 8'h01);

    // Load with pause on the very edge a step would fire.
    cyc(3);
    load = 1'b1; pause = 1'b1; pattern_in = 8'hA0;
    cyc(1);
    load = 1'b0; pause = 1'b0;
    chk("load_over_step_led", led, 8'hA0);
    chk("load_over_step_step", {7'b0, step}, 8'h00);
    cyc(3);
    chk("load_wait_led", led, 8'hA0);
    chk("load_wait_step", {7'b0, step}, 8'h00);
    cyc(1);
    chk("load_next_step_led", led, 8'h41);
    chk("load_next_step_pulse", {7'b0, step}, 8'h01);

    // Ping-pong to dir=right, then reset mid-period.
    mode = 2'd2;
    cyc(4);
    chk("ping2_left", led, 8'h82);
    cyc(4);
    chk("ping2_bounce", led, 8'h41);
    chk("ping2_dir_right", {7'b0, dbg_dir}, 8'h01);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_mid_led", led, 8'h0F);
    chk("rst_mid_dir", {7'b0, dbg_dir}, 8'h00);
    chk("rst_mid_step", {7'b0, step}, 8'h00);
    cyc(3);
    chk("rst_mid_pre_e4", led, 8'h0F);
    cyc(1);
    chk("rst_mid_e4", led, 8'h1E);
    chk("rst_mid_e4_step", {7'b0, step}, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
